// File: rtl/mod_counter_param_if.sv
// Bundle of control inputs and status outputs for mod_counter_param.
// The master side drives the controls and the slave side is the counter.
interface mod_counter_param_if #(
    parameter int WIDTH = 11,
    parameter int CNT_W = 8
);
    logic             en;
    logic             dir;
    logic             sat;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] c;
    logic             wrap;
    logic [CNT_W-1:0] wrap_cnt;
    logic             err;

    modport master (
        output en, dir, sat, load, load_val,
        input  c, wrap, wrap_cnt, err
    );

    modport slave (
        input  en, dir, sat, load, load_val,
        output c, wrap, wrap_cnt, err
    );
endinterface

// File: rtl/mod_counter_param.sv
// Up/down modulo counter over [RESTART, LIMIT] with load, wrap/saturate
// selection, a wrap pulse, a wrap tally and a sticky out-of-range load flag.
module mod_counter_param #(
    parameter int WIDTH   = 11,
    parameter int LIMIT   = 200,
    parameter int RESTART = 1,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mod_counter_param_if.slave    bus
);

    localparam logic [WIDTH-1:0] LIMIT_V   = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] RESTART_V = WIDTH'(RESTART);

    logic [WIDTH-1:0] c_r;
    logic             wrap_r;
    logic [CNT_W-1:0] wrap_cnt_r;
    logic             err_r;

    logic [WIDTH-1:0] c_nxt_s;
    logic             wrap_nxt_s;
    logic             err_nxt_s;

    // Next-state selection: load beats count, count beats hold.
    always_comb begin
        c_nxt_s    = c_r;
        wrap_nxt_s = 1'b0;
        err_nxt_s  = err_r;
        if (bus.load) begin
            if (bus.load_val <= LIMIT_V) begin
                c_nxt_s = bus.load_val;
            end else begin
                c_nxt_s   = LIMIT_V;
                err_nxt_s = 1'b1;
            end
        end else if (bus.en) begin
            if (!bus.dir) begin
                if (c_r != LIMIT_V) begin
                    c_nxt_s = c_r + WIDTH'(1);
                end else if (bus.sat) begin
                    c_nxt_s = c_r;
                end else begin
                    c_nxt_s    = RESTART_V;
                    wrap_nxt_s = 1'b1;
                end
            end else begin
                // Values below RESTART (e.g. 0 after reset) also take the boundary branch.
                if (c_r > RESTART_V) begin
                    c_nxt_s = c_r - WIDTH'(1);
                end else if (bus.sat) begin
                    c_nxt_s = c_r;
                end else begin
                    c_nxt_s    = LIMIT_V;
                    wrap_nxt_s = 1'b1;
                end
            end
        end else begin
            c_nxt_s = c_r;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_r        <= '0;
            wrap_r     <= 1'b0;
            wrap_cnt_r <= '0;
            err_r      <= 1'b0;
        end else begin
            c_r    <= c_nxt_s;
            wrap_r <= wrap_nxt_s;
            err_r  <= err_nxt_s;
            if (wrap_nxt_s) begin
                wrap_cnt_r <= wrap_cnt_r + CNT_W'(1);
            end else begin
                wrap_cnt_r <= wrap_cnt_r;
            end
        end
    end

    assign bus.c        = c_r;
    assign bus.wrap     = wrap_r;
    assign bus.wrap_cnt = wrap_cnt_r;
    assign bus.err      = err_r;

endmodule

// File: tb/tb_mod_counter_param.sv
// Randomized and directed bench for mod_counter_param (default parameters)
// against an integer reference model of the counting rules.
module tb_mod_counter_param;

    localparam int LIM = 200;
    localparam int RST = 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   m_c;
    int   m_wraps;
    bit   m_wrap;
    bit   m_err;

    mod_counter_param_if #(.WIDTH(11), .CNT_W(8)) bus ();

    mod_counter_param #(.WIDTH(11), .LIMIT(LIM), .RESTART(RST), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the reference model, settle past the edge.
    task automatic step(input bit r, input bit e, input bit d, input bit s,
                        input bit l, input int lv);
        rst_n        = r;
        bus.en       = e;
        bus.dir      = d;
        bus.sat      = s;
        bus.load     = l;
        bus.load_val = 11'(lv);
        @(posedge clk);
        m_wrap = 1'b0;
        if (!r) begin
            m_c = 0; m_wraps = 0; m_err = 1'b0;
        end else if (l) begin
            if ((lv % 2048) <= LIM) m_c = lv % 2048;
            else begin m_c = LIM; m_err = 1'b1; end
        end else if (e) begin
            if (!d) begin
                if (m_c < LIM) m_c = m_c + 1;
                else if (!s) begin m_c = RST; m_wrap = 1'b1; m_wraps++; end
            end else begin
                if (m_c > RST) m_c = m_c - 1;
                else if (!s) begin m_c = LIM; m_wrap = 1'b1; m_wraps++; end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 77);
        checks++;
        if (bus.c !== 11'd0 || bus.wrap !== 1'b0 || bus.wrap_cnt !== 8'd0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL reset: c=%0d wrap=%b wrap_cnt=%0d err=%b, need 0 0 0 0",
                     bus.c, bus.wrap, bus.wrap_cnt, bus.err);
        end
    endtask

    task automatic test_up_wrap();
        int pulses;
        pulses = 0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 1; i <= 201; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
            if (bus.wrap === 1'b1) pulses++;
            checks++;
            if (int'(bus.c) !== ((i <= LIM) ? i : RST)) begin
                errors++;
                $display("FAIL up_seq[%0d]: c=%0d need %0d", i, bus.c, (i <= LIM) ? i : RST);
            end
        end
        checks++;
        if (bus.wrap !== 1'b1 || pulses != 1 || bus.wrap_cnt !== 8'd1 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL up_wrap: wrap=%b pulses=%0d wrap_cnt=%0d err=%b, need 1 1 1 0",
                     bus.wrap, pulses, bus.wrap_cnt, bus.err);
        end
    endtask

    task automatic test_sat_up();
        int exp_c [5] = '{199, 200, 200, 200, 200};
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 198);
        checks++;
        if (bus.c !== 11'd198) begin
            errors++; $display("FAIL sat_load: c=%0d need 198", bus.c);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
            checks++;
            if (int'(bus.c) !== exp_c[i] || bus.wrap !== 1'b0) begin
                errors++;
                $display("FAIL sat_up[%0d]: c=%0d wrap=%b need %0d 0", i, bus.c, bus.wrap, exp_c[i]);
            end
        end
    endtask

    task automatic test_down();
        int  exp_c [3] = '{200, 199, 198};
        bit  exp_w [3] = '{1'b1, 1'b0, 1'b0};
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
            checks++;
            if (int'(bus.c) !== exp_c[i] || bus.wrap !== exp_w[i]) begin
                errors++;
                $display("FAIL down[%0d]: c=%0d wrap=%b need %0d %b", i, bus.c, bus.wrap, exp_c[i], exp_w[i]);
            end
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        checks++;
        if (bus.c !== 11'd1 || bus.wrap !== 1'b0) begin
            errors++; $display("FAIL down_to_restart: c=%0d wrap=%b need 1 0", bus.c, bus.wrap);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        checks++;
        if (bus.c !== 11'd200 || bus.wrap !== 1'b1 || bus.wrap_cnt !== 8'd2) begin
            errors++;
            $display("FAIL down_wrap: c=%0d wrap=%b wrap_cnt=%0d need 200 1 2", bus.c, bus.wrap, bus.wrap_cnt);
        end
    endtask

    task automatic test_load_err();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 300);
        checks++;
        if (bus.c !== 11'd200 || bus.err !== 1'b1 || bus.wrap !== 1'b0) begin
            errors++;
            $display("FAIL load_err: c=%0d err=%b wrap=%b need 200 1 0", bus.c, bus.err, bus.wrap);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        checks++;
        if (bus.err !== 1'b1 || bus.c !== 11'd0) begin
            errors++; $display("FAIL err_sticky: err=%b c=%0d need 1 0", bus.err, bus.c);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        checks++;
        if (bus.err !== 1'b0 || bus.c !== 11'd0) begin
            errors++; $display("FAIL err_clear: err=%b c=%0d need 0 0", bus.err, bus.c);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) != 0), $urandom_range(0, 3) != 0, 1'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 210));
            checks++;
            if (int'(bus.c) !== m_c || bus.wrap !== m_wrap ||
                int'(bus.wrap_cnt) !== (m_wraps % 256) || bus.err !== m_err) begin
                errors++;
                $display("FAIL random[%0d]: c=%0d wrap=%b wrap_cnt=%0d err=%b need %0d %b %0d %b",
                         i, bus.c, bus.wrap, bus.wrap_cnt, bus.err, m_c, m_wrap, m_wraps % 256, m_err);
            end
        end
    endtask

    task automatic test_rollover();
        int cyc;
        int bad;
        cyc = 0; bad = 0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        while (m_wraps < 256 && cyc < 60000) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
            cyc++;
            if (int'(bus.c) > LIM || int'(bus.c) !== m_c) bad++;
            if (m_wraps == 255 && m_wrap && bus.wrap_cnt !== 8'd255) bad++;
        end
        checks++;
        if (m_wraps != 256 || bad != 0 || bus.wrap_cnt !== 8'd0 || bus.wrap !== 1'b1) begin
            errors++;
            $display("FAIL rollover: wraps=%0d bad=%0d wrap_cnt=%0d wrap=%b need 256 0 0 1",
                     m_wraps, bad, bus.wrap_cnt, bus.wrap);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 200);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 150);
        checks++;
        if (bus.c !== 11'd150 || bus.wrap_cnt === 8'd0) begin
            errors++; $display("FAIL mid_setup: c=%0d wrap_cnt=%0d need 150 nonzero", bus.c, bus.wrap_cnt);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 150);
        checks++;
        if (bus.c !== 11'd0 || bus.wrap !== 1'b0 || bus.wrap_cnt !== 8'd0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: c=%0d wrap=%b wrap_cnt=%0d err=%b need 0 0 0 0",
                     bus.c, bus.wrap, bus.wrap_cnt, bus.err);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        m_c = 0; m_wraps = 0; m_wrap = 1'b0; m_err = 1'b0;
        rst_n = 1'b0; bus.en = 1'b0; bus.dir = 1'b0; bus.sat = 1'b0;
        bus.load = 1'b0; bus.load_val = 11'd0;
        test_reset();
        test_up_wrap();
        test_sat_up();
        test_down();
        test_load_err();
        test_random();
        test_rollover();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
